// File: rtl/cavlc_pkg.sv
// Shared definitions for the CAVLC total_zeros encoder.
//   tz_mode_e     : block-type encoding carried on in_mode
//   MAXC_*        : maxNumCoeff for each block type
//   TZ_MAX_LEN    : longest total_zeros code word (bits)
//   max_num_coeff : mode -> maxNumCoeff
package cavlc_pkg;

  typedef enum logic [1:0] {
    TZ_MODE_4x4_16 = 2'd0,
    TZ_MODE_4x4_15 = 2'd1,
    TZ_MODE_CDC420 = 2'd2,
    TZ_MODE_CDC422 = 2'd3
  } tz_mode_e;

  localparam logic [4:0] MAXC_4x4_16 = 5'd16;
  localparam logic [4:0] MAXC_4x4_15 = 5'd15;
  localparam logic [4:0] MAXC_CDC420 = 5'd4;
  localparam logic [4:0] MAXC_CDC422 = 5'd8;

  localparam int TZ_MAX_LEN = 9;

  function automatic logic [4:0] max_num_coeff(input logic [1:0] mode);
    logic [4:0] m;
    case (tz_mode_e'(mode))
      TZ_MODE_4x4_16: m = MAXC_4x4_16;
      TZ_MODE_4x4_15: m = MAXC_4x4_15;
      TZ_MODE_CDC420: m = MAXC_CDC420;
      default:        m = MAXC_CDC422;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cavlc_totalzeros_rom.sv
// Combinational total_zeros code lookup: (mode, TotalCoeff, total_zeros) -> {code, len}.
//   mode_i : block type (tz_mode_e encoding)
//   tc_i   : table index, TotalCoeff 1..15 (other values return len 0)
//   tz_i   : total_zeros
//   code_o : right-aligned code word, upper bits zero
//   len_o  : code length in bits
// Configuration macro CAVLC_TZ_CHROMA422_EN builds the 4:2:2 chroma DC table;
// without it mode 3 returns len 0.
module cavlc_totalzeros_rom
  import cavlc_pkg::*;
#(
  parameter int CODE_W = TZ_MAX_LEN
) (
  input  logic [1:0]        mode_i,
  input  logic [3:0]        tc_i,
  input  logic [3:0]        tz_i,
  output logic [CODE_W-1:0] code_o,
  output logic [3:0]        len_o
);

  // Each row packs 16 nibbles, total_zeros = 0 in the most significant nibble,
  // so the hex literals read left to right as tz = 0, 1, 2, ...
  // Every code value in these tables fits in 3 bits.
  localparam logic [63:0] TZ4_LEN [16] = '{
    64'h0,
    64'h1334_4556_6778_8999, 64'h3333_3444_4556_6660, 64'h4333_4433_4556_5600,
    64'h5344_3334_3455_5000, 64'h4443_3333_4545_0000, 64'h6533_3333_4360_0000,
    64'h6533_3234_3600_0000, 64'h6453_2233_6000_0000, 64'h6642_2325_0000_0000,
    64'h5532_2240_0000_0000, 64'h4433_1300_0000_0000, 64'h4421_3000_0000_0000,
    64'h3312_0000_0000_0000, 64'h2210_0000_0000_0000, 64'h1100_0000_0000_0000};
  localparam logic [63:0] TZ4_CODE [16] = '{
    64'h0,
    64'h1323_2323_2323_2321, 64'h7654_3543_2323_2100, 64'h5765_4343_2321_1000,
    64'h3754_6543_3221_0000, 64'h5437_6543_2110_0000, 64'h1176_5432_1100_0000,
    64'h1154_3321_1000_0000, 64'h1113_3221_0000_0000, 64'h1013_2111_0000_0000,
    64'h1013_2110_0000_0000, 64'h0112_1300_0000_0000, 64'h0111_1000_0000_0000,
    64'h0111_0000_0000_0000, 64'h0110_0000_0000_0000, 64'h0100_0000_0000_0000};

  localparam logic [63:0] TZ420_LEN [4] = '{
    64'h0, 64'h1233_0000_0000_0000, 64'h1220_0000_0000_0000, 64'h1100_0000_0000_0000};
  localparam logic [63:0] TZ420_CODE [4] = '{
    64'h0, 64'h1110_0000_0000_0000, 64'h1100_0000_0000_0000, 64'h1000_0000_0000_0000};

`ifdef CAVLC_TZ_CHROMA422_EN
  localparam logic [63:0] TZ422_LEN [8] = '{
    64'h0,
    64'h1334_4455_0000_0000, 64'h3233_3330_0000_0000, 64'h3322_3300_0000_0000,
    64'h3222_3000_0000_0000, 64'h2222_0000_0000_0000, 64'h2210_0000_0000_0000,
    64'h1100_0000_0000_0000};
  localparam logic [63:0] TZ422_CODE [8] = '{
    64'h0,
    64'h1232_3110_0000_0000, 64'h0114_5670_0000_0000, 64'h0112_6700_0000_0000,
    64'h6012_7000_0000_0000, 64'h0123_0000_0000_0000, 64'h0110_0000_0000_0000,
    64'h0100_0000_0000_0000};
`endif

  function automatic logic [3:0] nib(input logic [63:0] row, input logic [3:0] tz);
    return row[{~tz, 2'b00} +: 4];
  endfunction

  logic [63:0] len_row;
  logic [63:0] code_row;
  logic [3:0]  code_nib;

  always_comb begin
    len_row  = '0;
    code_row = '0;
    case (tz_mode_e'(mode_i))
      TZ_MODE_4x4_16, TZ_MODE_4x4_15: begin
        len_row  = TZ4_LEN[tc_i];
        code_row = TZ4_CODE[tc_i];
      end
      TZ_MODE_CDC420: begin
        if (tc_i < 4'd4) begin
          len_row  = TZ420_LEN[tc_i[1:0]];
          code_row = TZ420_CODE[tc_i[1:0]];
        end
      end
`ifdef CAVLC_TZ_CHROMA422_EN
      TZ_MODE_CDC422: begin
        if (tc_i < 4'd8) begin
          len_row  = TZ422_LEN[tc_i[2:0]];
          code_row = TZ422_CODE[tc_i[2:0]];
        end
      end
`endif
      default: ;
    endcase
    len_o    = nib(len_row, tz_i);
    code_nib = nib(code_row, tz_i);
    code_o   = CODE_W'(code_nib);
  end

endmodule

// File: rtl/cavlc_totalzeros_enc_pipe.sv
// Two-stage pipelined total_zeros VLC encoder with valid/ready flow control.
//   clk, rst (async, active-high)
//   in_valid/in_ready, in_mode, in_total_coeff, in_total_zeros, in_tag : descriptor input
//   out_valid/out_ready, out_code, out_len, out_tag, out_err            : code word output
//   bit_count : running sum of out_len over output transfers; clr_count clears it
// Configuration macro CAVLC_TZ_CHROMA422_EN enables mode 3 (4:2:2 chroma DC);
// without it every mode-3 descriptor is flagged out_err with len 0.
module cavlc_totalzeros_enc_pipe
  import cavlc_pkg::*;
#(
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 20,
  parameter int CODE_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [4:0]        in_total_coeff,
  input  logic [3:0]        in_total_zeros,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [3:0]        out_len,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic [CNT_W-1:0]  bit_count,
  input  logic              clr_count
);

  logic              vld_p1_q, vld_p2_q;
  logic [1:0]        mode_p1_q;
  logic [3:0]        idx_p1_q, tz_p1_q;
  logic [TAG_W-1:0]  tag_p1_q, tag_p2_q;
  logic              err_p1_q, skip_p1_q, err_p2_q;
  logic [CODE_W-1:0] code_p2_q, code_p2_d, rom_code;
  logic [3:0]        len_p2_q, len_p2_d, rom_len;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;

  logic              s2_adv, acc, ld_p2, xfer;
  logic [4:0]        maxc;
  logic              tc_over, tz_over, err_p1_d, skip_p1_d;

  assign s2_adv   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || s2_adv;
  assign acc      = in_valid && in_ready;
  assign ld_p2    = vld_p1_q && s2_adv;
  assign xfer     = vld_p2_q && out_ready;

  // ---- stage 1: classify descriptor, register index and flags ----
  always_comb begin
    maxc      = max_num_coeff(in_mode);
    tc_over   = in_total_coeff > maxc;
    // Only meaningful when TotalCoeff is in range, so the subtraction cannot wrap.
    tz_over   = !tc_over && (in_total_coeff != 5'd0) &&
                ({1'b0, in_total_zeros} > (maxc - in_total_coeff));
    err_p1_d  = tc_over || tz_over;
`ifndef CAVLC_TZ_CHROMA422_EN
    if (tz_mode_e'(in_mode) == TZ_MODE_CDC422) err_p1_d = 1'b1;
`endif
    skip_p1_d = (in_total_coeff == 5'd0) || (in_total_coeff == maxc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1_q <= 1'b0;
    else if (in_ready) vld_p1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      mode_p1_q <= in_mode;
      idx_p1_q  <= in_total_coeff[3:0];
      tz_p1_q   <= in_total_zeros;
      tag_p1_q  <= in_tag;
      err_p1_q  <= err_p1_d;
      skip_p1_q <= skip_p1_d;
    end
  end

  // ---- stage 2: table lookup, register code word ----
  cavlc_totalzeros_rom #(.CODE_W(CODE_W)) u_rom (
    .mode_i (mode_p1_q),
    .tc_i   (idx_p1_q),
    .tz_i   (tz_p1_q),
    .code_o (rom_code),
    .len_o  (rom_len)
  );

  always_comb begin
    code_p2_d = rom_code;
    len_p2_d  = rom_len;
    if (err_p1_q || skip_p1_q) begin
      code_p2_d = '0;
      len_p2_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      code_p2_q <= '0;
      len_p2_q  <= '0;
      tag_p2_q  <= '0;
      err_p2_q  <= 1'b0;
    end else begin
      if (s2_adv) vld_p2_q <= vld_p1_q;
      if (ld_p2) begin
        code_p2_q <= code_p2_d;
        len_p2_q  <= len_p2_d;
        tag_p2_q  <= tag_p1_q;
        err_p2_q  <= err_p1_q;
      end
    end
  end

  // ---- output: emitted-bit accumulator ----
  // A clear coincident with a transfer keeps that transfer's length.
  always_comb begin
    bit_count_d = bit_count_q;
    if (clr_count)  bit_count_d = xfer ? CNT_W'(len_p2_q) : '0;
    else if (xfer)  bit_count_d = bit_count_q + CNT_W'(len_p2_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bit_count_q <= '0;
    else     bit_count_q <= bit_count_d;
  end

  assign out_valid = vld_p2_q;
  assign out_code  = code_p2_q;
  assign out_len   = len_p2_q;
  assign out_tag   = tag_p2_q;
  assign out_err   = err_p2_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_cavlc_totalzeros_enc_pipe.sv
// Directed self-checking bench for cavlc_totalzeros_enc_pipe.
module tb_cavlc_totalzeros_enc_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_total_coeff = '0;
  logic [3:0]  in_total_zeros = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [8:0]  out_code;
  logic [3:0]  out_len;
  logic [4:0]  out_tag;
  logic        out_err;
  logic [19:0] bit_count;
  logic        clr_count = 1'b0;

  cavlc_totalzeros_enc_pipe #(.TAG_W(5), .CNT_W(20), .CODE_W(9)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_total_coeff(in_total_coeff), .in_total_zeros(in_total_zeros), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_len(out_len),
    .out_tag(out_tag), .out_err(out_err), .bit_count(bit_count), .clr_count(clr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] code;
    logic [3:0] len;
    logic       err;
    logic [4:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  int          n_del = 0;
  logic [19:0] exp_bc = '0;
  logic [4:0]  tag_ctr = '0;
  logic        bp_en = 1'b0;
  int          w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [4:0] tc, input logic [3:0] tz,
                      input logic [8:0] code, input logic [3:0] len, input logic err,
                      output int waited);
    exp_t e;
    in_mode = m; in_total_coeff = tc; in_total_zeros = tz; in_tag = tag_ctr;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(waited), 0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.code = code; e.len = len; e.err = err; e.tag = tag_ctr;
      exp_q.push_back(e);
      n_acc++;
      tag_ctr++;
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_rule", 32'(in_ready), 32'(!((n_acc - n_del) == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_code", 32'(out_code), 32'(mon_e.code));
          chk("out_len",  32'(out_len),  32'(mon_e.len));
          chk("out_err",  32'(out_err),  32'(mon_e.err));
          chk("out_tag",  32'(out_tag),  32'(mon_e.tag));
          exp_bc = exp_bc + 20'(mon_e.len);
          n_del++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_en) out_ready = ~out_ready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_code",  32'(out_code), 0);
    chk("rst_out_len",   32'(out_len), 0);
    chk("rst_out_tag",   32'(out_tag), 0);
    chk("rst_out_err",   32'(out_err), 0);
    chk("rst_bit_count", 32'(bit_count), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Latency, then full-rate mode 0 burst
    send(2'd0, 5'd1, 4'd0, 9'd1, 4'd1, 1'b0, w);
    chk("lat_not_yet", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_2cyc", 32'(out_valid), 1);
    send(2'd0, 5'd1, 4'd1,  9'd3, 4'd3, 1'b0, w);  chk("full_rate", 32'(w), 0);
    send(2'd0, 5'd1, 4'd15, 9'd1, 4'd9, 1'b0, w);  chk("full_rate", 32'(w), 0);
    wait_drain();
    chk("bc_13", 32'(bit_count), 13);

    // Skip, error and general 4x4 entries
    send(2'd1, 5'd15, 4'd0,  9'd0, 4'd0, 1'b0, w);
    send(2'd0, 5'd15, 4'd1,  9'd1, 4'd1, 1'b0, w);
    send(2'd0, 5'd16, 4'd0,  9'd0, 4'd0, 1'b0, w);
    send(2'd0, 5'd0,  4'd0,  9'd0, 4'd0, 1'b0, w);
    send(2'd0, 5'd17, 4'd0,  9'd0, 4'd0, 1'b1, w);
    send(2'd0, 5'd14, 4'd3,  9'd0, 4'd0, 1'b1, w);
    send(2'd0, 5'd2,  4'd14, 9'd0, 4'd6, 1'b0, w);
    send(2'd0, 5'd14, 4'd2,  9'd1, 4'd1, 1'b0, w);
    send(2'd1, 5'd14, 4'd1,  9'd1, 4'd2, 1'b0, w);
    send(2'd1, 5'd14, 4'd2,  9'd0, 4'd0, 1'b1, w);
    send(2'd1, 5'd16, 4'd0,  9'd0, 4'd0, 1'b1, w);
    send(2'd0, 5'd3,  4'd0,  9'd5, 4'd4, 1'b0, w);
    send(2'd0, 5'd7,  4'd5,  9'd3, 4'd2, 1'b0, w);
    send(2'd0, 5'd10, 4'd6,  9'd1, 4'd4, 1'b0, w);

    // Chroma DC 4:2:0
    send(2'd2, 5'd1, 4'd0, 9'd1, 4'd1, 1'b0, w);
    send(2'd2, 5'd1, 4'd3, 9'd0, 4'd3, 1'b0, w);
    send(2'd2, 5'd3, 4'd1, 9'd0, 4'd1, 1'b0, w);
    send(2'd2, 5'd4, 4'd0, 9'd0, 4'd0, 1'b0, w);
    send(2'd2, 5'd2, 4'd3, 9'd0, 4'd0, 1'b1, w);
    send(2'd2, 5'd5, 4'd0, 9'd0, 4'd0, 1'b1, w);
    send(2'd2, 5'd2, 4'd1, 9'd1, 4'd2, 1'b0, w);

    // Chroma DC 4:2:2
`ifdef CAVLC_TZ_CHROMA422_EN
    send(2'd3, 5'd1, 4'd0, 9'd1, 4'd1, 1'b0, w);
    send(2'd3, 5'd1, 4'd1, 9'd2, 4'd3, 1'b0, w);
    send(2'd3, 5'd4, 4'd0, 9'd6, 4'd3, 1'b0, w);
    send(2'd3, 5'd7, 4'd1, 9'd1, 4'd1, 1'b0, w);
    send(2'd3, 5'd8, 4'd0, 9'd0, 4'd0, 1'b0, w);
    send(2'd3, 5'd3, 4'd6, 9'd0, 4'd0, 1'b1, w);
`else
    send(2'd3, 5'd1, 4'd0, 9'd0, 4'd0, 1'b1, w);
    send(2'd3, 5'd1, 4'd1, 9'd0, 4'd0, 1'b1, w);
    send(2'd3, 5'd4, 4'd0, 9'd0, 4'd0, 1'b1, w);
    send(2'd3, 5'd8, 4'd0, 9'd0, 4'd0, 1'b1, w);
`endif
    wait_drain();
    chk("bc_after_tables", 32'(bit_count), 32'(exp_bc));

    // Back-pressure: out_ready toggles every cycle
    bp_en = 1'b1;
    send(2'd0, 5'd1, 4'd0, 9'd1, 4'd1, 1'b0, w);
    send(2'd0, 5'd1, 4'd1, 9'd3, 4'd3, 1'b0, w);
    send(2'd0, 5'd1, 4'd2, 9'd2, 4'd3, 1'b0, w);
    send(2'd0, 5'd1, 4'd3, 9'd3, 4'd4, 1'b0, w);
    send(2'd0, 5'd1, 4'd4, 9'd2, 4'd4, 1'b0, w);
    send(2'd0, 5'd1, 4'd5, 9'd3, 4'd5, 1'b0, w);
    wait_drain();
    bp_en = 1'b0;
    out_ready = 1'b1;
    chk("bp_delivered", 32'(n_del), 32'(n_acc));
    chk("bc_after_bp", 32'(bit_count), 32'(exp_bc));

    // Stall with two in flight, then asynchronous reset
    out_ready = 1'b0;
    send(2'd0, 5'd1, 4'd1, 9'd3, 4'd3, 1'b0, w);
    send(2'd0, 5'd1, 4'd0, 9'd1, 4'd1, 1'b0, w);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", 32'(out_valid), 1);
    chk("hold_len",   32'(out_len), 3);
    chk("hold_code",  32'(out_code), 3);
    chk("hold_in_ready", 32'(in_ready), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_bc",    32'(bit_count), 0);
    exp_q.delete();
    n_acc = 0; n_del = 0; exp_bc = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(2'd2, 5'd1, 4'd0, 9'd1, 4'd1, 1'b0, w);
    chk("post_rst_not_yet", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("post_rst_lat", 32'(out_valid), 1);
    wait_drain();
    chk("post_rst_bc", 32'(bit_count), 1);

    // Clear coincident with a length-3 transfer, then clear alone
    send(2'd0, 5'd1, 4'd1, 9'd3, 4'd3, 1'b0, w);
    @(posedge clk); #1;
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    chk("clr_with_xfer", 32'(bit_count), 3);
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    chk("clr_alone", 32'(bit_count), 0);
    chk("final_queue", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cavlc_totalzeros_enc_pipe.md
Name: cavlc_totalzeros_enc_pipe

Overview:
- Parametrised, pipelined total_zeros VLC encoder for the CAVLC residual path.
- Accepts one block descriptor per handshake: mode, total_coeff, total_zeros, sideband tag.
- Returns a right-aligned code word and length to the CAVLC bit packer.
- Over the single-cycle, state-gated encoder it adds:
  - valid/ready flow control;
  - explicit maxNumCoeff handling (16/15/4/8);
  - tag pass-through;
  - a running emitted-bit counter for rate control.

Parameters:
- TAG_W, 5: width of the sideband tag (block index) carried alongside each descriptor.
- CNT_W, 20: width of the emitted-bit accumulator.
- CODE_W, 9: output code field width; must be ≥9, the longest total_zeros code.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous reset, active-high.
- in_valid, input, 1: descriptor valid.
- in_ready, output, 1: encoder can accept a descriptor.
- in_mode, input, 2: 0 = 4x4 with maxNumCoeff 16; 1 = 4x4 with maxNumCoeff 15 (I16x16 AC / chroma AC); 2 = chroma DC 4:2:0 (max 4); 3 = chroma DC 4:2:2 (max 8).
- in_total_coeff, input, 5: TotalCoeff, 0..16.
- in_total_zeros, input, 4: total_zeros, 0..15.
- in_tag, input, TAG_W: sideband, returned unchanged.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_code, output, CODE_W: code bits, right-aligned, upper bits zero.
- out_len, output, 4: code length 0..9; 0 means nothing to emit.
- out_tag, output, TAG_W: tag of this result.
- out_err, output, 1: descriptor was illegal for its mode.
- bit_count, output, CNT_W: sum of out_len over all accepted outputs.
- clr_count, input, 1: synchronous clear of bit_count.

Behaviour:
- Reset (rst high, asynchronous): out_valid = 0, out_code = 0, out_len = 0, out_tag = 0, out_err = 0, bit_count = 0, both stage-valid flags = 0, in_ready = 1 once rst deasserts.
- Pipeline structure, two register stages:
  - S1 registers the input and computes the table index and skip/err flags.
  - S2 registers the looked-up code/len.
  - Latency is 2 cycles from input accept to out_valid when unstalled.
- Throughput: 1 descriptor per cycle.
- Handshake:
  - A transfer occurs when valid && ready.
  - A stage advances when its downstream is empty or being drained in the same cycle.
  - in_ready = !s1_valid || (s2 advances).
  - With out_ready low, out_* and out_valid hold stable and no data is lost or duplicated.
  - Upstream must hold in_* stable while in_valid && !in_ready.
- Skip rule: out_len = 0 and out_code = 0 (result still emitted, tag preserved) when either holds:
  - total_coeff == 0;
  - total_coeff == maxNumCoeff(mode), i.e. 16, 15, 4 or 8.
- Table selection:
  - Modes 0/1 use the 4x4 total_zeros table indexed by tzVlcIndex = total_coeff (1..15).
  - Mode 2 uses the 2x2 chroma DC table (tc 1..3).
  - Mode 3 uses the 2x4 chroma DC table (tc 1..7).
- Error rule: out_err = 1 and out_len = 0 when either holds:
  - total_coeff > maxNumCoeff;
  - total_zeros > maxNumCoeff − total_coeff (with total_coeff ≥ 1).
- bit_count:
  - Adds out_len on each output transfer (out_valid && out_ready), wrapping modulo 2^CNT_W.
  - clr_count in the same cycle as a transfer loads out_len rather than 0, so clear wins only over the old total.
- Concurrency:
  - Simultaneous input accept and output drain in the same cycle is legal and must sustain full rate.
  - rst asserted mid-stream discards all in-flight descriptors.

Optional Feature:
- Macro: CAVLC_TZ_CHROMA422_EN.
- Defined:
  - mode 3 is supported with the 4:2:2 chroma DC table;
  - bit_count includes mode-3 lengths.
- Undefined:
  - the 4:2:2 table is not built;
  - any mode-3 descriptor produces out_err = 1, out_len = 0, but still completes the handshake with its tag.

Decomposition:
- Shared package cavlc_pkg holds:
  - the mode encodings (TZ_MODE_4x4_16, TZ_MODE_4x4_15, TZ_MODE_CDC420, TZ_MODE_CDC422);
  - the maxNumCoeff constants;
  - the max-code-length constant 9.
- Sub-module cavlc_totalzeros_rom: purely combinational lookup of (mode, tc, tz) → {code, len}. The top holds the pipeline, handshake and counter.

Test Plan:
- Mode 0, (tc=1, tz=0) then (tc=1, tz=1) then (tc=1, tz=15), out_ready=1 → after 2 cycles each: code 1/len 1, code 3/len 3, code 1/len 9; bit_count = 13.
- Mode 1, tc=15 tz=0 → len 0. Mode 0, tc=15 tz=1 → code 1 len 1. Mode 0, tc=16 → len 0. Mode 0, tc=0 → len 0. Tags echoed in order.
- Mode 2: (1,0) → 1/1; (1,3) → 0/3; (3,1) → 0/1; (4,0) → len 0; (2,3) → out_err=1.
- Mode 3 with macro: (1,0) → 1/1; (1,1) → 2/3. Without macro: out_err=1, len 0.
- Back-pressure: 6 back-to-back descriptors, out_ready toggled 1010… → all 6 delivered in order, none dropped; in_ready low only when both stages are full and the output is stalled.
- rst pulsed with 2 descriptors in flight → out_valid=0 and bit_count=0 immediately; next descriptor emerges 2 cycles after accept. clr_count coincident with a transfer of len 3 → bit_count = 3.
